rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (AD3/WD3/RegWrite) between two requesters:
  - the in-order pipeline writeback, which has priority and never waits unless forced;
  - a multi-cycle execution unit (divider/multiplier), using a valid/ready handshake.
- Keeps a busy scoreboard of destination registers owned by in-flight multi-cycle ops and reports RAW/WAW hazards to decode.
- Adds anti-starvation: the pipeline is stalled for one cycle when the multi-cycle result has waited too long.
- Sits between the writeback stage, the multi-cycle unit and the register file.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_scoreboard.sv | 48 ++++
 rtl/rf_wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Optional performance counters are enabled with the RF_ARB_PERF_EN macro.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // Wide enough for MAX_WAIT up to 15.
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    // x0 is hardwired to zero; writes to it are dropped.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
        return (rd == '0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy vector for destination registers owned by in-flight multi-cycle ops,
// plus the RAW/WAW hazard lookup for decode.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    output logic                  hazard
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clear on handshake, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en && !is_x0(set_rd)) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Sources owned by a pending op (RAW) or a pipeline write to one (WAW).
    always_comb begin
        hazard = busy_q[rs1] | busy_q[rs2] | (pipe_we & busy_q[pipe_rd]);
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file's single write port between the in-order
// pipeline writeback (priority) and a multi-cycle unit (valid/ready), with
// anti-starvation forcing and a busy scoreboard for decode hazards.
// Define RF_ARB_PERF_EN to add saturating conflict/stall counters.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [DATA_WIDTH-1:0] pipe_wd,
    input  logic                  mc_issue,
    input  logic [REG_ADDR_W-1:0] mc_issue_rd,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_rd,
    input  logic [DATA_WIDTH-1:0] mc_wd,
    output logic                  mc_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_ad3,
    output logic [DATA_WIDTH-1:0] rf_wd3,
    output logic                  stall_pipe,
    output logic                  hazard
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0]           perf_conflict_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam logic [WAIT_CNT_W-1:0] MaxWaitCnt = WAIT_CNT_W'(MAX_WAIT);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_d;

    logic grant_pipe;
    logic grant_mc;
    logic force_stall;
    logic mc_handshake;
    logic sb_hazard;

    // Next-state and grant decision from the current requests.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        grant_pipe  = 1'b0;
        grant_mc    = 1'b0;
        force_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mc_valid && !pipe_we) begin
                    grant_mc = 1'b1;
                end else if (mc_valid && pipe_we) begin
                    grant_pipe = 1'b1;
                    wait_cnt_d = WAIT_CNT_W'(1);
                    // A limit of one means the very first denial triggers forcing.
                    state_d    = (MaxWaitCnt <= WAIT_CNT_W'(1)) ? FORCE : WAIT;
                end else begin
                    grant_pipe = pipe_we;
                end
            end
            WAIT: begin
                if (!mc_valid) begin
                    // Protocol violation: the pending result vanished.
                    grant_pipe = pipe_we;
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (!pipe_we) begin
                    grant_mc   = 1'b1;
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    grant_pipe = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                    if (wait_cnt_d >= MaxWaitCnt) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                // Pipeline holds; its write this cycle is not performed.
                force_stall = 1'b1;
                grant_mc    = mc_valid;
                state_d     = IDLE;
                wait_cnt_d  = '0;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Arbiter state and consecutive-denial counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Write-port mux; everything is held at zero while reset is asserted.
    always_comb begin
        mc_ready   = 1'b0;
        rf_we      = 1'b0;
        rf_ad3     = '0;
        rf_wd3     = '0;
        stall_pipe = 1'b0;
        hazard     = 1'b0;
        if (!rst) begin
            if (grant_mc) begin
                mc_ready = 1'b1;
                rf_we    = !is_x0(mc_rd);
                rf_ad3   = mc_rd;
                rf_wd3   = mc_wd;
            end else if (grant_pipe) begin
                rf_we    = pipe_we && !is_x0(pipe_rd);
                rf_ad3   = pipe_rd;
                rf_wd3   = pipe_wd;
            end
            stall_pipe = force_stall;
            hazard     = sb_hazard;
        end
    end

    // Handshake completes (and frees the destination) when the result is taken.
    always_comb begin
        mc_handshake = mc_valid && mc_ready;
    end

    rf_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (mc_issue),
        .set_rd  (mc_issue_rd),
        .clr_en  (mc_handshake),
        .clr_rd  (mc_rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .pipe_we (pipe_we),
        .pipe_rd (pipe_rd),
        .hazard  (sb_hazard)
    );

`ifdef RF_ARB_PERF_EN
    logic [31:0] conflict_q;
    logic [31:0] stall_q;

    // Saturating counters: cycles with both requesters active, and FORCE cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else begin
            if (pipe_we && mc_valid && (conflict_q != '1)) begin
                conflict_q <= conflict_q + 32'd1;
            end
            if ((state_q == FORCE) && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_conflict_cnt = conflict_q;
    assign perf_stall_cnt    = stall_q;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter. The driver applies inputs and
// queues the expected outputs; a monitor pops and compares on each negedge.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_wd = '0;
    logic        mc_issue = 1'b0;
    logic [4:0]  mc_issue_rd = '0;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_rd = '0;
    logic [31:0] mc_wd = '0;
    logic        mc_ready;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rf_we;
    logic [4:0]  rf_ad3;
    logic [31:0] rf_wd3;
    logic        stall_pipe;
    logic        hazard;

    typedef struct {
        string       nm;
        logic        we;
        logic [4:0]  ad;
        logic [31:0] wd;
        logic        rdy;
        logic        stl;
        logic        hz;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    event chk_ev;

    rf_wb_arbiter #(
        .DATA_WIDTH (32),
        .MAX_WAIT   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wd     (pipe_wd),
        .mc_issue    (mc_issue),
        .mc_issue_rd (mc_issue_rd),
        .mc_valid    (mc_valid),
        .mc_rd       (mc_rd),
        .mc_wd       (mc_wd),
        .mc_ready    (mc_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rf_we       (rf_we),
        .rf_ad3      (rf_ad3),
        .rf_wd3      (rf_wd3),
        .stall_pipe  (stall_pipe),
        .hazard      (hazard)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                         input logic iss, input logic [4:0] ird, input logic mv,
                         input logic [4:0] mrd, input logic [31:0] mwd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        pipe_we = pwe; pipe_rd = prd; pipe_wd = pwd;
        mc_issue = iss; mc_issue_rd = ird;
        mc_valid = mv; mc_rd = mrd; mc_wd = mwd;
        rs1 = r1; rs2 = r2;
    endtask

    task automatic push_exp(input string nm, input logic we, input logic [4:0] ad,
                            input logic [31:0] wd, input logic rdy, input logic stl,
                            input logic hz);
        exp_t e;
        e.nm = nm; e.we = we; e.ad = ad; e.wd = wd; e.rdy = rdy; e.stl = stl; e.hz = hz;
        q.push_back(e);
    endtask

    task automatic idle_zero(input string nm);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp(nm, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the oldest queued expectation against the DUT.
    always @(negedge clk or chk_ev) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (rf_we !== mon_e.we || rf_ad3 !== mon_e.ad || rf_wd3 !== mon_e.wd ||
                mc_ready !== mon_e.rdy || stall_pipe !== mon_e.stl || hazard !== mon_e.hz) begin
                failures++;
                $display("FAIL %s: got we=%0b ad3=%0d wd3=%h ready=%0b stall=%0b hazard=%0b; want we=%0b ad3=%0d wd3=%h ready=%0b stall=%0b hazard=%0b",
                         mon_e.nm, rf_we, rf_ad3, rf_wd3, mc_ready, stall_pipe, hazard,
                         mon_e.we, mon_e.ad, mon_e.wd, mon_e.rdy, mon_e.stl, mon_e.hz);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        // Outputs held at zero during reset even with active requests.
        drive(1, 3, 32'h55, 1, 6, 1, 4, 32'h44, 6, 0);
        push_exp("reset_outputs", 0, 0, 0, 0, 0, 0);
        idle_zero("reset_idle");
        rst = 1'b0;

        // Issue rd 5 (rd 6 issued during reset must not be busy).
        drive(0, 0, 0, 1, 5, 0, 0, 0, 6, 0);
        push_exp("issue5_no_busy6", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        push_exp("raw_rs1_5", 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
        push_exp("mc_grant_rd5", 1, 5, 32'hDEADBEEF, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        push_exp("busy5_cleared", 0, 0, 0, 0, 0, 0);

        // Starvation: pipe wins four times, then FORCE grants mc.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 2, 32'h11 * 32'(i), 0, 0, 1, 9, 32'hA5A5A5A5, 0, 0);
            push_exp("pipe_over_mc", 1, 2, 32'h11 * 32'(i), 0, 0, 0);
        end
        drive(1, 2, 32'h55, 0, 0, 1, 9, 32'hA5A5A5A5, 0, 0);
        push_exp("force_mc", 1, 9, 32'hA5A5A5A5, 1, 1, 0);
        drive(1, 2, 32'h66, 0, 0, 0, 0, 0, 0, 0);
        push_exp("pipe_after_force", 1, 2, 32'h66, 0, 0, 0);

        // WAIT resolved by a pipeline bubble.
        drive(1, 1, 32'h77, 0, 0, 1, 10, 32'h1010, 0, 0);
        push_exp("wait_enter", 1, 1, 32'h77, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 10, 32'h1010, 0, 0);
        push_exp("wait_mc_grant", 1, 10, 32'h1010, 1, 0, 0);
        idle_zero("after_wait_idle");

        // x0 writes suppressed but still handshake.
        drive(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        push_exp("pipe_x0", 0, 0, 32'h1234, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
        push_exp("mc_x0", 0, 0, 32'hFFFF, 1, 0, 0);

        // Simultaneous clear and set of rd 3: set wins.
        drive(0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        push_exp("issue3", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 1, 3, 32'h3333, 3, 0);
        push_exp("setclr3", 1, 3, 32'h3333, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        push_exp("busy3_kept", 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 3, 32'h4, 0, 3);
        push_exp("clr3", 1, 3, 32'h4, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        push_exp("busy3_cleared", 0, 0, 0, 0, 0, 0);

        // WAW: pipeline write to a pending destination.
        drive(0, 0, 0, 1, 12, 0, 0, 0, 0, 0);
        push_exp("issue12", 0, 0, 0, 0, 0, 0);
        drive(1, 12, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        push_exp("waw12", 1, 12, 32'h1, 0, 0, 1);
        drive(0, 12, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("no_waw_without_we", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 12, 32'h0, 0, 0);
        push_exp("clr12", 1, 12, 32'h0, 1, 0, 0);

        // Busy 8..11, drive into FORCE, then assert reset asynchronously.
        for (int r = 8; r <= 11; r++) begin
            drive(0, 0, 0, 1, 5'(r), 0, 0, 0, 0, 0);
            push_exp("issue_8_11", 0, 0, 0, 0, 0, 0);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 32'(i), 0, 0, 1, 8, 32'h88, 0, 0);
            push_exp("pipe_before_rst", 1, 1, 32'(i), 0, 0, 0);
        end
        drive(1, 1, 32'h5, 0, 0, 1, 8, 32'h88, 0, 0);
        push_exp("force_before_rst", 1, 8, 32'h88, 1, 1, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        push_exp("async_rst_in_force", 0, 0, 0, 0, 0, 0);
        ->chk_ev;
        idle_zero("rst_held");
        rst = 1'b0;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 8, 11);
        push_exp("busy_cleared_8_11", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
        push_exp("busy_cleared_9_10", 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h2, 0, 0, 1, 5, 32'h7, 0, 0);
        push_exp("idle_after_rst", 1, 1, 32'h2, 0, 0, 0);
        drive(1, 1, 32'h3, 0, 0, 1, 5, 32'h7, 0, 0);
        push_exp("wait_after_rst", 1, 1, 32'h3, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 5, 32'h7, 0, 0);
        push_exp("mc_after_rst", 1, 5, 32'h7, 1, 0, 0);
        idle_zero("final_idle");

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
